// File: rtl/l1_setassoc_tag_ctrl.sv
// ---------------------------------------------------------------------------
// l1_setassoc_tag_ctrl : set-associative L1 tag/valid/dirty/true-LRU controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module l1_setassoc_tag_ctrl #(
  parameter int WAYS       = 8,
  parameter int SETS       = 16384,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int CNT_W      = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [1:0]                                req_op,
  input  logic [ADDR_W-1:0]                         req_addr,
  output logic                                      rsp_valid,
  output logic                                      rsp_hit,
  output logic [$clog2(WAYS)-1:0]                   rsp_way,
  output logic                                      rsp_evict,
  output logic [ADDR_W-$clog2(SETS)-$clog2(LINE_BYTES)-1:0] rsp_evict_tag,
  output logic                                      rsp_writeback,
  output logic [CNT_W-1:0]                          hit_count,
  output logic [CNT_W-1:0]                          miss_count,
  output logic                                      init_done
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_INV = 2'd2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_UPDATE} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  init_idx_q;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;

  logic              req_ready_q, rsp_valid_q, rsp_hit_q, rsp_evict_q, rsp_writeback_q, init_done_q;
  logic [WAY_W-1:0]  rsp_way_q;
  logic [TAG_W-1:0]  rsp_evict_tag_q;
  logic [CNT_W-1:0]  hit_count_q, miss_count_q;

  logic [TAG_W-1:0]  tag_arr_q   [SETS][WAYS];
  logic [WAY_W-1:0]  rank_arr_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_arr_q [SETS];
  logic [WAYS-1:0]   dirty_arr_q [SETS];

  logic              w_hit, w_has_inv;
  logic [WAY_W-1:0]  w_hit_way, w_victim, w_acc_way, w_acc_rank;
  logic [WAY_W-1:0]  w_rank_upd [WAYS];
  logic              w_unused_off;

  assign w_unused_off = ^req_addr[OFF_W-1:0];

  // Descending scans so the lowest-index match / invalid way is the one kept.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_victim  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr_q[req_idx_q][w] && (tag_arr_q[req_idx_q][w] == req_tag_q)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!valid_arr_q[req_idx_q][w]) begin
        w_has_inv = 1'b1;
        w_victim  = WAY_W'(w);
      end
    end
    if (!w_has_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (rank_arr_q[req_idx_q][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
    w_acc_way  = w_hit ? w_hit_way : w_victim;
    w_acc_rank = rank_arr_q[req_idx_q][w_acc_way];
    for (int w = 0; w < WAYS; w++) begin
      w_rank_upd[w] = rank_arr_q[req_idx_q][w];
      if (WAY_W'(w) == w_acc_way)                      w_rank_upd[w] = '0;
      else if (rank_arr_q[req_idx_q][w] < w_acc_rank)  w_rank_upd[w] = rank_arr_q[req_idx_q][w] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_INIT;
      init_idx_q      <= '0;
      op_q            <= '0;
      req_tag_q       <= '0;
      req_idx_q       <= '0;
      req_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
      rsp_writeback_q <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      init_done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          valid_arr_q[init_idx_q] <= '0;
          dirty_arr_q[init_idx_q] <= '0;
          for (int w = 0; w < WAYS; w++) rank_arr_q[init_idx_q][w] <= WAY_W'(w);
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == IDX_W'(SETS - 1)) begin
            init_done_q <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            req_tag_q   <= req_addr[ADDR_W-1 -: TAG_W];
            req_idx_q   <= req_addr[OFF_W +: IDX_W];
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        // Arrays, counters and response registers all commit on the edge into UPDATE.
        S_LOOKUP: begin
          state_q         <= S_UPDATE;
          rsp_valid_q     <= 1'b1;
          rsp_hit_q       <= w_hit;
          rsp_evict_q     <= 1'b0;
          rsp_evict_tag_q <= '0;
          rsp_writeback_q <= 1'b0;
          if (op_q == OP_INV) begin
            rsp_way_q <= w_hit ? w_hit_way : '0;
            if (w_hit) begin
              rsp_writeback_q                    <= dirty_arr_q[req_idx_q][w_hit_way];
              valid_arr_q[req_idx_q][w_hit_way] <= 1'b0;
              dirty_arr_q[req_idx_q][w_hit_way] <= 1'b0;
            end
          end else begin
            rsp_way_q <= w_acc_way;
            for (int w = 0; w < WAYS; w++) rank_arr_q[req_idx_q][w] <= w_rank_upd[w];
            if (w_hit) begin
              if (op_q == OP_WR) dirty_arr_q[req_idx_q][w_hit_way] <= 1'b1;
              if (hit_count_q != '1) hit_count_q <= hit_count_q + 1'b1;
            end else begin
              rsp_evict_q <= valid_arr_q[req_idx_q][w_victim];
              if (valid_arr_q[req_idx_q][w_victim]) begin
                rsp_evict_tag_q <= tag_arr_q[req_idx_q][w_victim];
                rsp_writeback_q <= dirty_arr_q[req_idx_q][w_victim];
              end
              tag_arr_q[req_idx_q][w_victim]   <= req_tag_q;
              valid_arr_q[req_idx_q][w_victim] <= 1'b1;
              dirty_arr_q[req_idx_q][w_victim] <= (op_q == OP_WR);
              if (miss_count_q != '1) miss_count_q <= miss_count_q + 1'b1;
            end
          end
        end
        S_UPDATE: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_evict     = rsp_evict_q;
  assign rsp_evict_tag = rsp_evict_tag_q;
  assign rsp_writeback = rsp_writeback_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  assign init_done     = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_l1_setassoc_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1_setassoc_tag_ctrl : directed + random bench with an MRU-list cache model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_l1_setassoc_tag_ctrl;
  localparam int WAYS = 4, SETS = 16, ADDR_W = 32, LINE_BYTES = 64, CNT_W = 4;
  localparam int TAG_W = 22, WAY_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_valid, rsp_hit, rsp_evict, rsp_writeback, init_done;
  logic [WAY_W-1:0]  rsp_way;
  logic [TAG_W-1:0]  rsp_evict_tag;
  logic [CNT_W-1:0]  hit_count, miss_count;

  l1_setassoc_tag_ctrl #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W),
                         .LINE_BYTES(LINE_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
    .rsp_writeback(rsp_writeback), .hit_count(hit_count), .miss_count(miss_count),
    .init_done(init_done));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    int due; int hit; int way; int evict; int etag; int wb; int hc; int mc;
  } rsp_t;
  rsp_t pend[$];
  rsp_t last;

  // Model: per-set arrays plus an MRU-first ordering of way numbers.
  int m_tag [SETS][WAYS];
  int m_val [SETS][WAYS];
  int m_dty [SETS][WAYS];
  int m_ord [SETS][WAYS];
  int m_hc, m_mc;

  int s_hit, s_way, s_evict, s_etag, s_wb, s_hc, s_mc, s_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic rsp_t zero_rsp();
    rsp_t r;
    r.due = 0; r.hit = 0; r.way = 0; r.evict = 0; r.etag = 0; r.wb = 0; r.hc = 0; r.mc = 0;
    return r;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_val[s][w] = 0; m_dty[s][w] = 0; m_ord[s][w] = w;
      end
    m_hc = 0; m_mc = 0;
  endfunction

  function automatic void touch(input int idx, input int way);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (m_ord[idx][i] == way) p = i;
    for (int i = p; i > 0; i--) m_ord[idx][i] = m_ord[idx][i-1];
    m_ord[idx][0] = way;
  endfunction

  function automatic rsp_t model_access(input int op, input logic [31:0] addr);
    rsp_t r = zero_rsp();
    int tag = int'(addr >> 10);
    int idx = int'((addr >> 6) & 32'hF);
    int hw = -1;
    int v  = -1;
    for (int w = 0; w < WAYS; w++)
      if (hw < 0 && m_val[idx][w] != 0 && m_tag[idx][w] == tag) hw = w;
    if (op == 2) begin
      if (hw >= 0) begin
        r.hit = 1; r.way = hw; r.wb = m_dty[idx][hw];
        m_val[idx][hw] = 0; m_dty[idx][hw] = 0;
      end
    end else if (hw >= 0) begin
      r.hit = 1; r.way = hw;
      if (op == 1) m_dty[idx][hw] = 1;
      if (m_hc < CMAX) m_hc++;
      touch(idx, hw);
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) if (m_val[idx][w] == 0) v = w;
      if (v < 0) v = m_ord[idx][WAYS-1];
      r.way = v; r.evict = m_val[idx][v];
      if (m_val[idx][v] != 0) begin r.etag = m_tag[idx][v]; r.wb = m_dty[idx][v]; end
      m_tag[idx][v] = tag; m_val[idx][v] = 1; m_dty[idx][v] = (op == 1) ? 1 : 0;
      if (m_mc < CMAX) m_mc++;
      touch(idx, v);
    end
    r.hc = m_hc; r.mc = m_mc;
    return r;
  endfunction

  task automatic check_cycle();
    if (rst) return;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      last = pend.pop_front();
      chk("rsp_valid_strobe", int'(rsp_valid), 1);
    end else begin
      chk("rsp_valid_quiet", int'(rsp_valid), 0);
    end
    chk("rsp_hit", int'(rsp_hit), last.hit);
    chk("rsp_way", int'(rsp_way), last.way);
    chk("rsp_evict", int'(rsp_evict), last.evict);
    chk("rsp_evict_tag", int'(rsp_evict_tag), last.etag);
    chk("rsp_writeback", int'(rsp_writeback), last.wb);
    chk("hit_count", int'(hit_count), last.hc);
    chk("miss_count", int'(miss_count), last.mc);
  endtask

  task automatic rst_now();
    rst = 1'b1; req_valid = 1'b0;
    pend.delete(); last = zero_rsp(); model_reset();
    @(posedge clk); #1 rst = 1'b0;
    chk("init_done_after_rst", int'(init_done), 0);
    chk("req_ready_after_rst", int'(req_ready), 0);
    chk("hit_count_after_rst", int'(hit_count), 0);
    chk("miss_count_after_rst", int'(miss_count), 0);
    begin
      int n = 0;
      while (!init_done && n < 100) begin
        chk("req_ready_in_init", int'(req_ready), 0);
        @(posedge clk); #1 n++;
      end
      chk("init_cycles", n, SETS);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_now();
  endtask

  task automatic do_req(input int op, input logic [31:0] addr, output int acc);
    int n = 0;
    rsp_t r;
    req_valid = 1'b1; req_op = 2'(op); req_addr = addr;
    while (!req_ready && n < 50) begin @(posedge clk); #1 n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    r = model_access(op, addr);
    r.due = cyc + 2;
    pend.push_back(r);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    s_cyc = -1;
    while (n < 10) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    s_hit = int'(rsp_hit); s_way = int'(rsp_way); s_evict = int'(rsp_evict);
    s_etag = int'(rsp_evict_tag); s_wb = int'(rsp_writeback);
    s_hc = int'(hit_count); s_mc = int'(miss_count); s_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic req_rsp(input int op, input logic [31:0] addr, output int acc);
    do_req(op, addr, acc);
    wait_rsp();
  endtask

  initial begin
    int a0, a1, dummy, hc0, mc0;
    last = zero_rsp();
    model_reset();
    fork
      forever begin @(negedge clk); check_cycle(); end
    join_none

    do_reset();

    // First miss into an empty set.
    req_rsp(0, 32'h40, a0);
    chk("lat_first", s_cyc - a0, 2);
    chk("first_hit", s_hit, 0);
    chk("first_way", s_way, 0);
    chk("first_mc", s_mc, 1);
    chk("first_evict", s_evict, 0);

    req_rsp(0, 32'h40, a1);
    chk("accept_spacing", a1 - a0, 3);
    chk("rep_hit", s_hit, 1);
    chk("rep_way", s_way, 0);
    chk("rep_hc", s_hc, 1);

    // Fill set 1, dirty tag 1, make it LRU, then force its eviction.
    for (int k = 1; k < 4; k++) begin
      req_rsp(0, 32'h40 + 32'(k) * 32'h400, dummy);
      chk("fill_way", s_way, k);
    end
    req_rsp(1, 32'h440, dummy);
    req_rsp(0, 32'h40, dummy);
    req_rsp(0, 32'h840, dummy);
    req_rsp(0, 32'hC40, dummy);
    req_rsp(0, 32'h1040, dummy);
    chk("evict_hit", s_hit, 0);
    chk("evict_way", s_way, 1);
    chk("evict_flag", s_evict, 1);
    chk("evict_tag", s_etag, 1);
    chk("evict_wb", s_wb, 1);
    chk("evict_mc", s_mc, 5);
    hc0 = s_hc; mc0 = s_mc;

    req_rsp(2, 32'h840, dummy);
    chk("inv_hit", s_hit, 1);
    chk("inv_way", s_way, 2);
    chk("inv_hc", s_hc, hc0);
    chk("inv_mc", s_mc, mc0);
    req_rsp(0, 32'h1440, dummy);
    chk("post_inv_way", s_way, 2);
    chk("post_inv_evict", s_evict, 0);

    for (int i = 0; i < 20; i++) req_rsp(0, 32'h40, dummy);
    chk("hit_sat", s_hc, CMAX);

    // Randomized traffic over a few sets and a small tag pool.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] addr;
      addr = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 2)) << 6)
           | 32'($urandom_range(0, 63));
      do_req(int'($urandom_range(0, 3)), addr, dummy);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("random_drained", pend.size(), 0);

    // Reset while a lookup is in flight.
    req_rsp(0, 32'h40, dummy);
    do_req(0, 32'h40, dummy);
    rst_now();
    chk("abort_hc", int'(hit_count), 0);
    req_rsp(0, 32'h40, dummy);
    chk("after_abort_hit", s_hit, 0);
    chk("after_abort_mc", s_mc, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
